// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV32 subset (lh, sh, sub, or, andi, srl, beq, addi).
// Optional: define CTRL_HALT_ON_ILLEGAL_EN to trap illegal instructions into ERROR instead of retiring them as NOPs.
module controle_multiciclo #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             tgt_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_sel,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             busy,
  output logic             err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WLIM = WW'(MEM_TIMEOUT - 1);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_OR = 3'd2, OP_AND = 3'd3, OP_SRL = 3'd4;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, ERROR
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_r, is_i, is_ld, is_st, is_br, is_ill, rd_nz, retire;
  logic       unused_instr;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rd_nz = |instr[11:7];
  assign unused_instr = ^instr[24:15];

  assign is_r  = (opc == 7'b0110011) &&
                 (((f3 == 3'b000) && (f7 == 7'b0100000)) ||
                  ((f3 == 3'b110) && (f7 == 7'b0000000)) ||
                  ((f3 == 3'b101) && (f7 == 7'b0000000)));
  assign is_i  = (opc == 7'b0010011) && ((f3 == 3'b000) || (f3 == 3'b111));
  assign is_ld = (opc == 7'b0000011) && (f3 == 3'b001);
  assign is_st = (opc == 7'b0100011) && (f3 == 3'b001);
  assign is_br = (opc == 7'b1100011) && (f3 == 3'b000);
  assign is_ill = !(is_r || is_i || is_ld || is_st || is_br);

`ifdef CTRL_HALT_ON_ILLEGAL_EN
  localparam logic ILL_RETIRES = 1'b0;
`else
  localparam logic ILL_RETIRES = 1'b1;
`endif

  assign retire = (state == WB_ALU) || (state == WB_MEM) || (state == BRANCH) ||
                  ((state == MEM_WR) && mem_ready) ||
                  ((state == DECODE) && is_ill && ILL_RETIRES);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      case (state)
        IDLE:     if (run) state <= FETCH;
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          if (is_r)                state <= EXEC_R;
          else if (is_i)           state <= EXEC_I;
          else if (is_ld || is_st) state <= MEM_ADDR;
          else if (is_br)          state <= BRANCH;
          else if (ILL_RETIRES)    state <= run ? FETCH : IDLE;
          else                     state <= ERROR;
        end
        EXEC_R, EXEC_I: state <= WB_ALU;
        MEM_ADDR: state <= is_st ? MEM_WR : MEM_RD;
        MEM_RD:   if (mem_ready) state <= WB_MEM;
        MEM_WR:   if (mem_ready) state <= run ? FETCH : IDLE;
        WB_ALU, WB_MEM, BRANCH: state <= run ? FETCH : IDLE;
        ERROR:    state <= ERROR;
        default:  state <= IDLE;
      endcase
      // A stalled access can only leave its state via mem_ready or timeout, so
      // clearing on mem_ready also covers the clear-on-state-change case.
      if (mem_req && !mem_ready) begin
        if (wait_cnt == WLIM) begin
          state    <= ERROR;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + WW'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    tgt_write = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    imm_sel   = 2'd0;
    alu_op    = OP_ADD;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    err       = (state == ERROR);
    busy      = (state != IDLE) && (state != ERROR);
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd2;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_sel   = 2'd2;
        tgt_write = 1'b1;
        illegal   = is_ill;
      end
      EXEC_R: begin
        alu_src_a = 2'd1;
        alu_op    = (f3 == 3'b000) ? OP_SUB : (f3 == 3'b110) ? OP_OR : OP_SRL;
      end
      EXEC_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        alu_op    = (f3 == 3'b111) ? OP_AND : OP_ADD;
      end
      MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_sel   = is_st ? 2'd1 : 2'd0;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      WB_ALU: reg_write = rd_nz;
      WB_MEM: begin
        reg_write = rd_nz;
        wb_sel    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 2'd1;
        alu_op    = OP_SUB;
        pc_write  = zero;
        pc_src    = zero;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: driver queues per-cycle expected outputs, monitor compares.
module tb_controle_multiciclo;
  logic        clk = 1'b0;
  logic        reset, run, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, tgt_write;
  logic [1:0]  alu_src_a, alu_src_b, imm_sel;
  logic [2:0]  alu_op;
  logic        reg_write, wb_sel, busy, err, illegal;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  controle_multiciclo #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .tgt_write(tgt_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_sel(imm_sel), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .busy(busy),
    .err(err), .illegal(illegal), .instr_count(instr_count)
  );

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, tgt_write;
    logic [1:0] a, b, imm;
    logic [2:0] op;
    logic reg_write, wb_sel, busy, err, illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  outs_t got;

  assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, tgt_write,
                alu_src_a, alu_src_b, imm_sel, alu_op, reg_write, wb_sel, busy, err, illegal};

  function automatic outs_t e_idle();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t e_fetch(input logic r);
    outs_t o = '0;
    o.mem_req = 1; o.b = 2; o.ir_write = r; o.pc_write = r; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_dec(input logic ill);
    outs_t o = '0;
    o.a = 2; o.b = 1; o.imm = 2; o.tgt_write = 1; o.illegal = ill; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_alu(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] imm, input logic [2:0] op);
    outs_t o = '0;
    o.a = a; o.b = b; o.imm = imm; o.op = op; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_mem(input logic we);
    outs_t o = '0;
    o.mem_req = 1; o.iord = 1; o.mem_we = we; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_wb(input logic rw, input logic ws);
    outs_t o = '0;
    o.reg_write = rw; o.wb_sel = ws; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_br(input logic z);
    outs_t o = '0;
    o.a = 1; o.op = 1; o.pc_write = z; o.pc_src = z; o.busy = 1;
    return o;
  endfunction
  function automatic outs_t e_err();
    outs_t o = '0;
    o.err = 1;
    return o;
  endfunction

  // Queue what this cycle must look like, then advance one clock.
  task automatic cyc(input outs_t o, input int cnt, input string nm);
    exp_t e;
    e.o = o; e.cnt = 32'(cnt); e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (got !== e.o || instr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got outs=%h cnt=%0d, expected outs=%h cnt=%0d",
                 e.nm, got, instr_count, e.o, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, %0d vectors pending", sb.size());
    $fatal(1);
  end

  initial begin
    reset = 0; run = 0; zero = 0; mem_ready = 1; instr = 32'h0;
    @(posedge clk); #1;
    cyc(e_idle(), 0, "reset_idle");
    reset = 1; run = 1;
    cyc(e_idle(), 0, "idle_run");
    // addi x1,x0,5
    instr = 32'h00500093;
    cyc(e_fetch(1), 0, "addi_fetch");
    cyc(e_dec(0), 0, "addi_dec");
    cyc(e_alu(1, 1, 0, 0), 0, "addi_exec");
    cyc(e_wb(1, 0), 0, "addi_wb");
    // lh x2,0(x1) with three stall cycles
    instr = 32'h00009103;
    cyc(e_fetch(1), 1, "lh_fetch");
    cyc(e_dec(0), 1, "lh_dec");
    cyc(e_alu(1, 1, 0, 0), 1, "lh_addr");
    mem_ready = 0;
    for (int i = 0; i < 3; i++) cyc(e_mem(0), 1, "lh_stall");
    mem_ready = 1;
    cyc(e_mem(0), 1, "lh_rd");
    cyc(e_wb(1, 1), 1, "lh_wb");
    // beq x1,x1,8 taken then not taken
    instr = 32'h00108463; zero = 1;
    cyc(e_fetch(1), 2, "beq_t_fetch");
    cyc(e_dec(0), 2, "beq_t_dec");
    cyc(e_br(1), 2, "beq_taken");
    zero = 0;
    cyc(e_fetch(1), 3, "beq_n_fetch");
    cyc(e_dec(0), 3, "beq_n_dec");
    cyc(e_br(0), 3, "beq_not_taken");
    // addi x0,x0,1: no register write
    instr = 32'h00100013;
    cyc(e_fetch(1), 4, "addi0_fetch");
    cyc(e_dec(0), 4, "addi0_dec");
    cyc(e_alu(1, 1, 0, 0), 4, "addi0_exec");
    cyc(e_wb(0, 0), 4, "addi0_wb_rd0");
    // andi x6,x1,7
    instr = 32'h0070F313;
    cyc(e_fetch(1), 5, "andi_fetch");
    cyc(e_dec(0), 5, "andi_dec");
    cyc(e_alu(1, 1, 0, 3), 5, "andi_exec");
    cyc(e_wb(1, 0), 5, "andi_wb");
    // or x4,x1,x2
    instr = 32'h0020E233;
    cyc(e_fetch(1), 6, "or_fetch");
    cyc(e_dec(0), 6, "or_dec");
    cyc(e_alu(1, 0, 0, 2), 6, "or_exec");
    cyc(e_wb(1, 0), 6, "or_wb");
    // srl x5,x1,x2
    instr = 32'h0020D2B3;
    cyc(e_fetch(1), 7, "srl_fetch");
    cyc(e_dec(0), 7, "srl_dec");
    cyc(e_alu(1, 0, 0, 4), 7, "srl_exec");
    cyc(e_wb(1, 0), 7, "srl_wb");
    // sh x2,4(x1)
    instr = 32'h00209223;
    cyc(e_fetch(1), 8, "sh_fetch");
    cyc(e_dec(0), 8, "sh_dec");
    cyc(e_alu(1, 1, 1, 0), 8, "sh_addr");
    cyc(e_mem(1), 8, "sh_wr");
    // sub x3,x1,x2 with run dropped mid-instruction
    instr = 32'h402081B3;
    cyc(e_fetch(1), 9, "sub_fetch");
    cyc(e_dec(0), 9, "sub_dec");
    run = 0;
    cyc(e_alu(1, 0, 0, 1), 9, "sub_exec");
    cyc(e_wb(1, 0), 9, "sub_wb");
    cyc(e_idle(), 10, "stop_idle");
    cyc(e_idle(), 10, "stop_idle2");
    // illegal opcode
    run = 1;
    cyc(e_idle(), 10, "ill_idle");
    instr = 32'h0000007F;
    cyc(e_fetch(1), 10, "ill_fetch");
    run = 0;
    cyc(e_dec(1), 10, "ill_dec");
`ifdef CTRL_HALT_ON_ILLEGAL_EN
    cyc(e_err(), 10, "ill_err");
    cyc(e_err(), 10, "ill_err_sticky");
    reset = 0;
    cyc(e_err(), 10, "ill_rst");
`else
    cyc(e_idle(), 11, "ill_nop_idle");
    reset = 0;
    cyc(e_idle(), 11, "ill_rst");
`endif
    reset = 1;
    cyc(e_idle(), 0, "post_rst");
    // fetch timeout
    run = 1;
    cyc(e_idle(), 0, "to_idle_run");
    mem_ready = 0;
    for (int i = 0; i < 4; i++) cyc(e_fetch(0), 0, "to_wait");
    cyc(e_err(), 0, "to_err");
    mem_ready = 1;
    cyc(e_err(), 0, "to_err_sticky");
    run = 0; reset = 0;
    cyc(e_err(), 0, "to_rst");
    reset = 1;
    cyc(e_idle(), 0, "to_cleared");
    // reset in the middle of a stalled fetch
    run = 1;
    cyc(e_idle(), 0, "mid_idle_run");
    mem_ready = 0;
    cyc(e_fetch(0), 0, "mid_wait");
    reset = 0;
    cyc(e_fetch(0), 0, "mid_rst");
    reset = 1; run = 0;
    cyc(e_idle(), 0, "mid_dropped");
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
